link_framer: RTL and testbench

- Sits directly downstream of the priority-encoder memory readout stage. Consumes the merged 54-bit stream (data, valid, done) and frames each bunch crossing (BX) into a tagged packet: header, data words, trailer.
- A FIFO absorbs back-pressure from the inter-board link serializer, which pulls words through a valid/ready handshake.

---
 rtl/link_framer_pkg.sv | 30 +++
 rtl/link_fifo.sv | 68 ++++++
 rtl/link_framer.sv | 170 +++++++++++++++++
 tb/tb_link_framer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_framer_pkg.sv
// Shared constants for the link framer: word type codes, header/trailer field
// offsets and the CRC-8 parameters used when LINK_FRAMER_CRC_EN is defined.
package link_framer_pkg;

    localparam logic [1:0] TYPE_HDR = 2'b01;
    localparam logic [1:0] TYPE_DAT = 2'b10;
    localparam logic [1:0] TYPE_TRL = 2'b11;

    localparam int unsigned BX_W = 3;

    localparam int unsigned HDR_BX_LSB  = 0;
    localparam int unsigned HDR_SEQ_LSB = 3;

    // Trailer fields above the word count are placed relative to COUNT_W.
    localparam int unsigned TRL_CNT_LSB   = 0;
    localparam int unsigned TRL_TRUNC_OFS = 0;
    localparam int unsigned TRL_OVF_OFS   = 1;
    localparam int unsigned TRL_BX_OFS    = 2;
    localparam int unsigned TRL_CRC_OFS   = 5;

    localparam int unsigned    CRC_W    = 8;
    localparam logic [7:0]     CRC_POLY = 8'h07;
    localparam logic [7:0]     CRC_INIT = 8'hFF;

    typedef enum logic [0:0] {
        WIdle,
        WOpen
    } wr_state_e;

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// fill counts entries held in the storage array, not the word in the output register.
module link_fifo #(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      fill_q;
    logic [WIDTH-1:0] dout_q;
    logic             dvalid_q;

    logic pop, load, mem_rd, mem_wr, bypass;

    always_comb begin
        pop    = dvalid_q & out_ready;
        load   = ~dvalid_q | pop;
        mem_rd = load & (fill_q != '0);
        // An empty array lets a new word go straight to the output register.
        bypass = load & (fill_q == '0) & push;
        mem_wr = push & ~bypass & ((fill_q != Full) | mem_rd);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
            if (mem_rd) begin
                dout_q   <= mem_q[rd_ptr_q];
                dvalid_q <= 1'b1;
            end else if (bypass) begin
                dout_q   <= push_data;
                dvalid_q <= 1'b1;
            end else if (pop) begin
                dvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[wr_ptr_q] <= push_data;
    end

    assign out_data  = dout_q;
    assign out_valid = dvalid_q;
    assign fill      = fill_q;

endmodule

// File: rtl/link_framer.sv
// Frames the merged memory stream into HDR/DAT/TRL link packets per bunch crossing.
// Define LINK_FRAMER_CRC_EN to append a CRC-8 of the DAT payloads to each trailer.
module link_framer
    import link_framer_pkg::*;
#(
    parameter int unsigned DATA_W     = 54,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned SETUP_CYC  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_event,
    input  logic [2:0]                    BX,
    input  logic [DATA_W-1:0]             mem_dat_stream,
    input  logic                          valid,
    input  logic                          done,
    output logic [DATA_W+1:0]             link_dat,
    output logic                          link_valid,
    input  logic                          link_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_fill,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_W = (SETUP_CYC > 0) ? $clog2(SETUP_CYC + 1) : 1;
    // Two slots stay free so a trailer and the following header always fit.
    localparam logic [AW:0] DatLimit = (AW+1)'(FIFO_DEPTH - 2);

    wr_state_e          state_q;
    logic [COUNT_W-1:0] seq_q, cnt_q;
    logic [BX_W-1:0]    bx_q;
    logic               ovf_q, hdr_pend_q;
    logic [TMR_W-1:0]   timer_q;
    logic [15:0]        drop_q;

    logic               hdr_now, trl_now, trunc_now, dat_now, ovf_now, lost_now;
    logic [BX_W-1:0]    hdr_bx;
    logic [DATA_W-1:0]  hdr_pay, trl_pay;
    logic               push;
    logic [DATA_W+1:0]  push_data;

`ifdef LINK_FRAMER_CRC_EN
    logic [CRC_W-1:0] crc_q;

    function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                   input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            else                      c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_comb begin
        hdr_now   = 1'b0;
        trl_now   = 1'b0;
        trunc_now = 1'b0;
        dat_now   = 1'b0;
        ovf_now   = 1'b0;
        lost_now  = 1'b0;
        hdr_bx    = BX;
        unique case (state_q)
            WIdle: hdr_now = new_event;
            WOpen: begin
                if (hdr_pend_q) begin
                    hdr_now  = 1'b1;
                    hdr_bx   = bx_q;
                    lost_now = valid;
                end else if (new_event) begin
                    trl_now   = 1'b1;
                    trunc_now = 1'b1;
                    lost_now  = valid;
                end else if (valid) begin
                    dat_now = (fifo_fill < DatLimit);
                    ovf_now = ~dat_now;
                end else if (done && timer_q == '0) begin
                    trl_now = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        hdr_pay = '0;
        hdr_pay[HDR_BX_LSB +: BX_W]     = hdr_bx;
        hdr_pay[HDR_SEQ_LSB +: COUNT_W] = seq_q;

        trl_pay = '0;
        trl_pay[TRL_CNT_LSB +: COUNT_W]       = cnt_q;
        trl_pay[COUNT_W + TRL_TRUNC_OFS]      = trunc_now;
        trl_pay[COUNT_W + TRL_OVF_OFS]        = ovf_q;
        trl_pay[COUNT_W + TRL_BX_OFS +: BX_W] = bx_q;
`ifdef LINK_FRAMER_CRC_EN
        trl_pay[COUNT_W + TRL_CRC_OFS +: CRC_W] = crc_q;
`endif

        push = hdr_now | trl_now | dat_now;
        if (hdr_now)      push_data = {TYPE_HDR, hdr_pay};
        else if (trl_now) push_data = {TYPE_TRL, trl_pay};
        else              push_data = {TYPE_DAT, mem_dat_stream};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WIdle;
            seq_q      <= '0;
            cnt_q      <= '0;
            bx_q       <= '0;
            ovf_q      <= 1'b0;
            hdr_pend_q <= 1'b0;
            timer_q    <= '0;
            drop_q     <= '0;
`ifdef LINK_FRAMER_CRC_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            if ((ovf_now || lost_now) && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

            if (hdr_now) begin
                state_q    <= WOpen;
                seq_q      <= seq_q + COUNT_W'(1);
                bx_q       <= hdr_bx;
                cnt_q      <= '0;
                ovf_q      <= 1'b0;
                hdr_pend_q <= 1'b0;
                timer_q    <= TMR_W'(SETUP_CYC);
`ifdef LINK_FRAMER_CRC_EN
                crc_q      <= CRC_INIT;
`endif
            end else begin
                if (timer_q != '0) timer_q <= timer_q - TMR_W'(1);
                // A truncating trailer keeps the FSM open; the new header follows next cycle.
                if (trl_now && trunc_now) begin
                    hdr_pend_q <= 1'b1;
                    bx_q       <= BX;
                end else if (trl_now) begin
                    state_q <= WIdle;
                end
                if (dat_now) begin
                    if (cnt_q != '1) cnt_q <= cnt_q + COUNT_W'(1);
`ifdef LINK_FRAMER_CRC_EN
                    crc_q <= crc8_next(crc_q, mem_dat_stream);
`endif
                end
                if (ovf_now) ovf_q <= 1'b1;
            end
        end
    end

    link_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .out_data  (link_dat),
        .out_valid (link_valid),
        .out_ready (link_ready),
        .fill      (fifo_fill)
    );

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_link_framer.sv
// Directed and randomized bench for link_framer, checked against a packet-level model.
// Build with LINK_FRAMER_CRC_EN defined to also check the trailer CRC field.
module tb_link_framer;

    localparam int DW    = 54;
    localparam int DEPTH = 64;
    localparam int SETUP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_event;
    logic [2:0]    BX;
    logic [DW-1:0] mem_dat_stream;
    logic          valid;
    logic          done;
    logic [DW+1:0] link_dat;
    logic          link_valid;
    logic          link_ready;
    logic [6:0]    fifo_fill;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    link_framer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .COUNT_W    (8),
        .SETUP_CYC  (SETUP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .new_event      (new_event),
        .BX             (BX),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .done           (done),
        .link_dat       (link_dat),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .fifo_fill      (fifo_fill),
        .drop_cnt       (drop_cnt)
    );

    int            chk = 0;
    int            errs = 0;
    int            cyc_n = 0;
    logic          rand_ready = 1'b0;
    logic [55:0]   got[$];
    int            got_t[$];
    logic [55:0]   exp_q[$];
    logic [7:0]    exp_seq = 8'd0;
    int            exp_drops = 0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [55:0]   prev_d = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        chk++;
        assert (obs === req) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Observe the link side: record accepted words and check hold-under-stall.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(link_valid), 64'd1);
                check("hold_dat", 64'(link_dat), 64'(prev_d));
            end
            if (link_valid && link_ready) begin
                got.push_back(link_dat);
                got_t.push_back(cyc_n);
            end
        end
        prev_v <= link_valid;
        prev_r <= link_ready;
        prev_d <= link_dat;
    end

    function automatic logic [53:0] rnd54();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[53:0];
    endfunction

    function automatic logic [7:0] crc_ref(input logic [53:0] d[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        foreach (d[k]) begin
            for (int b = 53; b >= 0; b--) begin
                fb = c[7] ^ d[k][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Append HDR, stored data words and the closing TRL of one packet to the expectation.
    task automatic add_pkt(input logic [2:0] bx, input logic [53:0] d[$],
                           input logic trunc, input logic ovf);
        logic [55:0] w;
        w = '0;
        w[55:54] = 2'b01;
        w[2:0]   = bx;
        w[10:3]  = exp_seq;
        exp_q.push_back(w);
        exp_seq = exp_seq + 8'd1;
        foreach (d[i]) exp_q.push_back({2'b10, d[i]});
        w = '0;
        w[55:54] = 2'b11;
        w[7:0]   = 8'(d.size());
        w[8]     = trunc;
        w[9]     = ovf;
        w[12:10] = bx;
`ifdef LINK_FRAMER_CRC_EN
        w[20:13] = crc_ref(d);
`endif
        exp_q.push_back(w);
    endtask

    task automatic step(input logic ne, input logic [2:0] bx, input logic v,
                        input logic [53:0] d, input logic dn);
        new_event      = ne;
        BX             = bx;
        valid          = v;
        mem_dat_stream = d;
        done           = dn;
        if (rand_ready) link_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 54'd0, 1'b0);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        link_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!link_valid && fifo_fill == 7'd0) break;
            idle(1);
        end
        idle(2);
        check("drain_valid", 64'(link_valid), 64'd0);
        check("drain_fill", 64'(fifo_fill), 64'd0);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [53:0] dq[$];
        logic [53:0] none[$];
        logic [2:0]  b;
        int          sent;

        // Reset with activity on the inputs
        reset = 1'b0;
        link_ready = 1'b1;
        step(1'b0, 3'd0, 1'b1, rnd54(), 1'b0);
        step(1'b0, 3'd0, 1'b1, rnd54(), 1'b0);
        check("rst_valid", 64'(link_valid), 64'd0);
        check("rst_fill", 64'(fifo_fill), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_dat", 64'(link_dat), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, rnd54(), 1'b1);
        idle(3);
        check("rst_no_words", 64'(got.size()), 64'd0);

        // Basic packet
        step(1'b1, 3'd5, 1'b0, 54'd0, 1'b0);
        idle(3);
        step(1'b0, 3'd0, 1'b1, 54'h1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 54'h2, 1'b0);
        step(1'b0, 3'd0, 1'b1, 54'h3, 1'b0);
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        drain();
        dq = '{54'h1, 54'h2, 54'h3};
        add_pkt(3'd5, dq, 1'b0, 1'b0);
        compare("basic");
        check("basic_drop", 64'(drop_cnt), 64'(exp_drops));

        // Truncation by a second new_event, with a word lost in the pending cycle
        dq = '{rnd54(), rnd54()};
        step(1'b1, 3'd2, 1'b0, 54'd0, 1'b0);
        step(1'b0, 3'd0, 1'b1, dq[0], 1'b0);
        step(1'b0, 3'd0, 1'b1, dq[1], 1'b0);
        step(1'b1, 3'd3, 1'b0, 54'd0, 1'b0);
        step(1'b0, 3'd0, 1'b1, rnd54(), 1'b0);
        exp_drops++;
        idle(4);
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        drain();
        add_pkt(3'd2, dq, 1'b1, 1'b0);
        add_pkt(3'd3, none, 1'b0, 1'b0);
        if (got_t.size() >= 5) check("trunc_hdr_next_cycle", 64'(got_t[4] - got_t[3]), 64'd1);
        compare("trunc");
        check("trunc_drop", 64'(drop_cnt), 64'(exp_drops));

        // Setup window: early done pulse is ignored
        b = 3'($urandom_range(0, 7));
        step(1'b1, b, 1'b0, 54'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        idle(6);
        check("setup_only_hdr", 64'(got.size()), 64'd1);
        check("setup_no_trl", 64'(link_valid), 64'd0);
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        drain();
        add_pkt(b, none, 1'b0, 1'b0);
        compare("setup_a");

        // Setup window: done held high from the cycle after new_event
        b = 3'($urandom_range(0, 7));
        step(1'b1, b, 1'b0, 54'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        drain();
        if (got_t.size() >= 2) check("setup_trl_gap", 64'(got_t[1] - got_t[0]), 64'(SETUP + 1));
        add_pkt(b, none, 1'b0, 1'b0);
        compare("setup_b");

        // Back-pressure: random link_ready over a 20-word packet
        dq.delete();
        b = 3'($urandom_range(0, 7));
        rand_ready = 1'b1;
        step(1'b1, b, 1'b0, 54'd0, 1'b0);
        sent = 0;
        for (int i = 0; i < 200 && sent < 20; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                dq.push_back(rnd54());
                step(1'b0, 3'd0, 1'b1, dq[sent], 1'b0);
                sent++;
            end else begin
                idle(1);
            end
        end
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        for (int i = 0; i < 10; i++) idle(1);
        drain();
        add_pkt(b, dq, 1'b0, 1'b0);
        compare("bp");

        // Overflow: 70 words into a stalled link
        dq.delete();
        b = 3'($urandom_range(0, 7));
        link_ready = 1'b0;
        step(1'b1, b, 1'b0, 54'd0, 1'b0);
        for (int i = 0; i < 70; i++) begin
            logic [53:0] w;
            w = rnd54();
            if (i < DEPTH - 2) dq.push_back(w);
            step(1'b0, 3'd0, 1'b1, w, 1'b0);
        end
        exp_drops += 70 - (DEPTH - 2);
        step(1'b0, 3'd0, 1'b0, 54'd0, 1'b1);
        idle(2);
        check("ovf_drop", 64'(drop_cnt), 64'(exp_drops));
        check("ovf_fill_bound", 64'(fifo_fill <= 7'(DEPTH)), 64'd1);
        check("ovf_stalled", 64'(got.size()), 64'd0);
        drain();
        add_pkt(b, dq, 1'b0, 1'b1);
        compare("ovf");
        check("ovf_drop_final", 64'(drop_cnt), 64'(exp_drops));

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
